// File: rtl/sw_rr_arbiter.sv
// Round-robin arbiter for four debounced switch requesters.
// Bounded hold time, one-cycle release gap, registered outputs.
module sw_rr_arbiter #(
   parameter int DEB_CYCLES  = 240000,
   parameter int HOLD_CYCLES = 12000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld,
   output logic [3:0] led_n
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_REL   = 2'd2;

   logic [3:0]         sync1_q, sync2_q;
   logic [3:0]         req_db_q, req_db_d;
   logic [3:0][DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]         state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [3:0]         gnt_q, gnt_d;
   logic [1:0]         idx_q, idx_d;
   logic               vld_q, vld_d;
   logic [3:0]         led_q, led_d;
   logic [1:0]         win, cand;
   logic               win_vld;

   // Counter only runs while the synced level disagrees with the debounced one
   always_comb begin
      req_db_d  = req_db_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == req_db_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == DEB_MAX) begin
            req_db_d[i]  = sync2_q[i];
            deb_cnt_d[i] = '0;
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      win     = ptr_q;
      win_vld = 1'b0;
      cand    = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!win_vld && req_db_q[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   // RELEASE arbitrates like IDLE so the zero gap is exactly one cycle
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      unique case (state_q)
         S_IDLE, S_REL: begin
            if (win_vld) begin
               state_d = S_GRANT;
               gnt_d   = 4'b0001 << win;
               idx_d   = win;
               vld_d   = 1'b1;
               hold_d  = HOLD_MAX;
            end else begin
               state_d = S_IDLE;
               gnt_d   = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
            end
         end
         S_GRANT: begin
            if (hold_q == '0 || !req_db_q[idx_q]) begin
               state_d = S_REL;
               ptr_d   = idx_q + 2'd1;
               gnt_d   = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
         end
      endcase
      led_d = ~gnt_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         req_db_q  <= '0;
         deb_cnt_q <= '0;
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         hold_q    <= '0;
         gnt_q     <= '0;
         idx_q     <= '0;
         vld_q     <= 1'b0;
         led_q     <= 4'b1111;
      end else begin
         sync1_q   <= sw;
         sync2_q   <= sync1_q;
         req_db_q  <= req_db_d;
         deb_cnt_q <= deb_cnt_d;
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         vld_q     <= vld_d;
         led_q     <= led_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;
   assign led_n   = led_q;

endmodule

// File: tb/tb_sw_rr_arbiter.sv
// Directed bench for sw_rr_arbiter with DEB_CYCLES=4, HOLD_CYCLES=8.
// Inputs change on negedges; outputs are sampled on negedges.
module tb_sw_rr_arbiter;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic [3:0] sw;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic [3:0] led_n;

   int checks;
   int failures;

   typedef struct {
      bit         rst;
      logic [3:0] sw;
      int         dly;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
      string      name;
   } vec_t;

   vec_t tbl[$];

   sw_rr_arbiter #(
      .DEB_CYCLES (4),
      .HOLD_CYCLES(8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw     (sw),
      .gnt    (gnt),
      .gnt_idx(gnt_idx),
      .gnt_vld(gnt_vld),
      .led_n  (led_n)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic chk(input string nm, input logic [3:0] eg,
                      input logic [1:0] ei, input logic ev);
      checks++;
      if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev ||
          led_n !== ~eg) begin
         failures++;
         $display("FAIL %s: got gnt=%b idx=%0d vld=%b led_n=%b, want gnt=%b idx=%0d vld=%b led_n=%b",
                  nm, gnt, gnt_idx, gnt_vld, led_n, eg, ei, ev, ~eg);
      end
   endtask

   task automatic add(input bit r, input logic [3:0] s, input int d,
                      input logic [3:0] g, input logic [1:0] i,
                      input logic v, input string nm);
      vec_t e;
      e.rst = r; e.sw = s; e.dly = d;
      e.gnt = g; e.idx = i; e.vld = v; e.name = nm;
      tbl.push_back(e);
   endtask

   task automatic pulse_reset(input logic [3:0] s);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sw    = s;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clk_en   = 1'b0;
      rst_n    = 1'b1;
      sw       = 4'b0000;

      // single requester: rise 7 after, 8 cycles held, 1 gap, regrant
      add(1, 4'b0001, 6, 4'b0000, 2'd0, 1'b0, "single_pre");
      add(0, 4'b0001, 1, 4'b0001, 2'd0, 1'b1, "single_rise");
      add(0, 4'b0001, 7, 4'b0001, 2'd0, 1'b1, "single_last");
      add(0, 4'b0001, 1, 4'b0000, 2'd0, 1'b0, "single_gap");
      add(0, 4'b0001, 1, 4'b0001, 2'd0, 1'b1, "single_regrant");
      add(0, 4'b0001, 7, 4'b0001, 2'd0, 1'b1, "single_re_last");
      add(0, 4'b0001, 1, 4'b0000, 2'd0, 1'b0, "single_gap2");
      // rotation with all four requesting
      add(1, 4'b1111, 6, 4'b0000, 2'd0, 1'b0, "rot_pre");
      add(0, 4'b1111, 1, 4'b0001, 2'd0, 1'b1, "rot0_first");
      add(0, 4'b1111, 7, 4'b0001, 2'd0, 1'b1, "rot0_last");
      add(0, 4'b1111, 1, 4'b0000, 2'd0, 1'b0, "rot_gap0");
      add(0, 4'b1111, 1, 4'b0010, 2'd1, 1'b1, "rot1_first");
      add(0, 4'b1111, 7, 4'b0010, 2'd1, 1'b1, "rot1_last");
      add(0, 4'b1111, 1, 4'b0000, 2'd0, 1'b0, "rot_gap1");
      add(0, 4'b1111, 1, 4'b0100, 2'd2, 1'b1, "rot2_first");
      add(0, 4'b1111, 7, 4'b0100, 2'd2, 1'b1, "rot2_last");
      add(0, 4'b1111, 1, 4'b0000, 2'd0, 1'b0, "rot_gap2");
      add(0, 4'b1111, 1, 4'b1000, 2'd3, 1'b1, "rot3_first");
      add(0, 4'b1111, 7, 4'b1000, 2'd3, 1'b1, "rot3_last");
      add(0, 4'b1111, 1, 4'b0000, 2'd0, 1'b0, "rot_gap3");
      add(0, 4'b1111, 1, 4'b0001, 2'd0, 1'b1, "rot_wrap0");
      // early drop: request falls before hold expires, ptr moves to 3
      add(1, 4'b0100, 5, 4'b0000, 2'd0, 1'b0, "drop_pre");
      add(0, 4'b0000, 2, 4'b0100, 2'd2, 1'b1, "drop_grant");
      add(0, 4'b0000, 4, 4'b0100, 2'd2, 1'b1, "drop_still");
      add(0, 4'b0000, 1, 4'b0000, 2'd0, 1'b0, "drop_early_fall");
      add(0, 4'b1001, 6, 4'b0000, 2'd0, 1'b0, "drop_ptr_pre");
      add(0, 4'b1001, 1, 4'b1000, 2'd3, 1'b1, "drop_ptr3");

      #2;
      rst_n = 1'b0;
      sw    = 4'b1111;
      #1;
      chk("reset_async", 4'b0000, 2'd0, 1'b0);

      clk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sw    = 4'b0000;
      @(negedge clk);

      foreach (tbl[n]) begin
         if (tbl[n].rst) pulse_reset(tbl[n].sw);
         else sw = tbl[n].sw;
         repeat (tbl[n].dly) @(negedge clk);
         chk(tbl[n].name, tbl[n].gnt, tbl[n].idx, tbl[n].vld);
      end

      // bounce on sw[1]: never stable long enough to register
      pulse_reset(4'b0000);
      for (int i = 0; i < 15; i++) begin
         sw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         repeat (2) @(negedge clk);
         chk("bounce_quiet", 4'b0000, 2'd0, 1'b0);
      end
      sw = 4'b0000;
      repeat (10) @(negedge clk);
      chk("bounce_settled", 4'b0000, 2'd0, 1'b0);
      sw = 4'b0010;
      repeat (6) @(negedge clk);
      chk("stable1_pre", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      chk("stable1_grant", 4'b0010, 2'd1, 1'b1);

      // reset in the middle of the second rotation grant
      pulse_reset(4'b1111);
      repeat (20) @(negedge clk);
      chk("midgrant_before", 4'b0010, 2'd1, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midgrant_async_clear", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("midgrant_redebounce", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      chk("midgrant_ptr_reset", 4'b0001, 2'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
